inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_pkg.sv | 24 ++
 rtl/inst_fetch_ctrl_cache.sv | 47 ++++
 rtl/inst_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl_pkg : fetch FSM encoding, I-cache geometry, reset constants
// Rev 1.0
// ============================================================================
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam int          ICACHE_LINES = 16;
  localparam int          IDX_W        = $clog2(ICACHE_LINES);
  localparam int          TAG_W        = 30 - IDX_W;
  localparam logic [31:0] RST_ADDR     = 32'hffff_ffff;

  function automatic logic [31:0] byte_addr(input logic [29:0] word, input logic [1:0] lane);
    return {word, lane};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_cache.sv
`default_nettype none
// ============================================================================
// inst_cache : 16-line direct-mapped instruction cache, one word per line
// Rev 1.0
// ============================================================================
module inst_cache
  import inst_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_addr_i,
  output logic        hit_o,
  output logic [31:0] data_o,
  input  logic        fill_i,
  input  logic [29:0] fill_addr_i,
  input  logic [31:0] fill_data_i
);

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];
  logic [IDX_W-1:0]        lk_idx;
  logic [IDX_W-1:0]        fl_idx;

  assign lk_idx = lookup_addr_i[IDX_W-1:0];
  assign fl_idx = fill_addr_i[IDX_W-1:0];
  assign hit_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_addr_i[29:IDX_W]);
  assign data_o = data_q[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[fl_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: a line is only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[fl_idx]  <= fill_addr_i[29:IDX_W];
      data_q[fl_idx] <= fill_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl : byte-serial 32-bit instruction fetch; ICACHE_EN adds I-cache
// Rev 1.0
// ============================================================================
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_re,
  input  logic [31:0] inst_raddr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din
);

  fetch_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic         pend_q, pend_d;
  logic [1:0]   pidx_q, pidx_d;
  logic [29:0]  base_q, base_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  buf_q, buf_d;
  logic         busy_q, busy_d;
  logic [31:0]  cap_word;
  logic         accept;
  logic         fill;
  logic         unused_lane;

`ifdef ICACHE_EN
  logic        hit;
  logic [31:0] hit_data;

  inst_cache u_cache (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr_i(inst_raddr[31:2]),
    .hit_o        (hit),
    .data_o       (hit_data),
    .fill_i       (fill),
    .fill_addr_i  (base_q),
    .fill_data_i  (cap_word)
  );
  assign unused_lane = ^inst_raddr[1:0];
`else
  assign unused_lane = ^{inst_raddr[1:0], fill};
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pidx_d   = pidx_q;
    base_d   = base_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    buf_d    = buf_q;
    busy_d   = busy_q;
    fill     = 1'b0;
    // Byte returned this cycle merged into its lane of the assembly buffer.
    cap_word = buf_q;
    cap_word[{pidx_q, 3'b000} +: 8] = mem_din;
    accept   = inst_re && ((state_q == S_IDLE) || flush);

    if (rdy) begin
      if (pend_q) buf_d = cap_word;
      pend_d = 1'b0;

      case (state_q)
        S_ISSUE: begin
          if (mem_grant) begin
            pend_d = 1'b1;
            pidx_d = idx_q;
            if (idx_q == 2'd3) begin
              state_d = S_DRAIN;
            end else begin
              idx_d  = idx_q + 2'd1;
              addr_d = byte_addr(base_q, idx_q + 2'd1);
            end
          end
        end
        S_DRAIN: begin
          if (pend_q) begin
            inst_d  = cap_word;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            fill    = 1'b1;
          end
        end
        default: ;
      endcase

      // An aborted fetch must leave inst and the cache untouched.
      if (flush) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
        inst_d  = inst_q;
        fill    = 1'b0;
      end

      if (accept) begin
        base_d = inst_raddr[31:2];
`ifdef ICACHE_EN
        if (hit) inst_d = hit_data;
        else
`endif
        begin
          state_d = S_ISSUE;
          idx_d   = 2'd0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          buf_d   = '0;
          addr_d  = byte_addr(inst_raddr[31:2], 2'd0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      base_q  <= '0;
      addr_q  <= RST_ADDR;
      inst_q  <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
    end
  end

  assign inst      = inst_q;
  assign inst_busy = busy_q;
  assign mem_req   = (state_q == S_ISSUE);
  assign mem_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// tb_inst_fetch_ctrl : directed and randomized fetches checked against a word-level
// memory/cache model; the memory returns junk for any byte it did not grant.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, inst_re, flush, mem_grant;
  logic [31:0] inst_raddr, inst, mem_addr;
  logic        inst_busy, mem_req;
  logic [7:0]  mem_din;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem [0:4095];
  bit          cv [16];
  logic [25:0] ct [16];
  bit          gq [$];
  bit          rq [$];

  inst_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .inst_re   (inst_re),
    .inst_raddr(inst_raddr),
    .flush     (flush),
    .inst      (inst),
    .inst_busy (inst_busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_grant (mem_grant),
    .mem_din   (mem_din)
  );

  always #5 clk = ~clk;

  // Byte memory behind the arbiter: stalls with rdy, one-cycle read latency.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_req && mem_grant) mem_din <= mem[mem_addr[11:0]];
      else                      mem_din <= 8'($urandom);
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef ICACHE_EN
    return cv[a[5:2]] && (ct[a[5:2]] == a[31:6]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_fill(input logic [31:0] a);
    cv[a[5:2]] = 1'b1;
    ct[a[5:2]] = a[31:6];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) cv[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch from request to completion; n returns busy cycles (0 on a hit).
  task automatic run_fetch(input logic [31:0] addr, input bit with_flush, input int gpct,
                           input int rpct, input bit noise, output int n);
    logic [31:0] exp_w, prev, base, exp_a;
    bit          hit, done, r, g;
    int          ng;
    exp_w = word_at(addr);
    prev  = inst;
    base  = {addr[31:2], 2'b00};
    hit   = model_hit(addr);
    inst_re = 1'b1; inst_raddr = addr; flush = with_flush; rdy = 1'b1; mem_grant = 1'b0;
    tick();
    inst_re = 1'b0; flush = 1'b0;
    n = 0;
    if (hit) begin
      n_checks++;
      if (inst_busy !== 1'b0 || inst !== exp_w) begin
        n_fail++;
        $display("FAIL hit@%h: busy=%b inst=%h, want busy=0 inst=%h", addr, inst_busy, inst, exp_w);
      end
    end else begin
      ng = 0; done = 1'b0;
      while (!done && n < 200) begin
        exp_a = base + 32'((ng < 4) ? ng : 3);
        n_checks++;
        if (inst_busy !== 1'b1 || mem_req !== (ng < 4) || mem_addr !== exp_a || inst !== prev) begin
          n_fail++;
          $display("FAIL busy_cycle@%h n=%0d: busy=%b req=%b addr=%h inst=%h, want 1 %b %h %h",
                   addr, n, inst_busy, mem_req, mem_addr, inst, (ng < 4), exp_a, prev);
        end
        if (rq.size() > 0) r = rq.pop_front(); else r = ($urandom_range(1, 100) <= rpct);
        if (gq.size() > 0) g = gq.pop_front(); else g = ($urandom_range(1, 100) <= gpct);
        rdy = r; mem_grant = g;
        if (noise) begin
          inst_re = 1'($urandom_range(0, 1));
          inst_raddr = $urandom;
        end
        tick();
        n++;
        if (r) begin
          if (ng < 4) ng += int'(g);
          else        done = 1'b1;
        end
      end
      inst_re = 1'b0; rdy = 1'b1; mem_grant = 1'b0;
      n_checks++;
      if (!done || inst_busy !== 1'b0 || inst !== exp_w) begin
        n_fail++;
        $display("FAIL done@%h: done=%b busy=%b inst=%h, want 1 0 %h", addr, done, inst_busy, inst, exp_w);
      end
      model_fill(addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; inst_re = 1'b0; flush = 1'b0; mem_grant = 1'b0; inst_raddr = '0;
    tick(); tick();
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: %h want 0", inst); end
    n_checks++; if (inst_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b want 0", inst_busy); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 32'hffff_ffff) begin n_fail++; $display("FAIL rst_addr: %h want ffffffff", mem_addr); end
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_basic();
    int n;
    run_fetch(32'h102, 1'b0, 100, 100, 1'b0, n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL basic_busy: %0d cycles want 5", n); end
    n_checks++; if (inst !== 32'h0050_0013) begin n_fail++; $display("FAIL basic_word: %h want 00500013", inst); end
  endtask

  task automatic test_grant_stall();
    int n;
    gq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_fetch(32'h180, 1'b0, 100, 100, 1'b0, n);
    n_checks++; if (n !== 7) begin n_fail++; $display("FAIL grant_stall_busy: %0d cycles want 7", n); end
  endtask

  task automatic test_rdy_stall();
    int n;
    rq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_fetch(32'h244, 1'b0, 100, 100, 1'b0, n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL rdy_stall_busy: %0d cycles want 8", n); end
  endtask

  task automatic test_reset_mid();
    inst_re = 1'b1; inst_raddr = 32'h300; mem_grant = 1'b1;
    tick();
    inst_re = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL midrst_inst: %h want 0", inst); end
    n_checks++; if (inst_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: %b want 0", inst_busy); end
    n_checks++; if (mem_addr !== 32'hffff_ffff) begin n_fail++; $display("FAIL midrst_addr: %h want ffffffff", mem_addr); end
    rst = 1'b0; mem_grant = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_flush_redirect();
    int n;
    inst_re = 1'b1; inst_raddr = 32'h3a0; mem_grant = 1'b1;
    tick();
    inst_re = 1'b0;
    tick();
    run_fetch(32'h200, 1'b1, 100, 100, 1'b0, n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL redirect_busy: %0d cycles want 5", n); end
  endtask

  task automatic test_flush_abort();
    logic [31:0] prev;
    int n;
    prev = inst;
    inst_re = 1'b1; inst_raddr = 32'h344; mem_grant = 1'b1;
    tick();
    inst_re = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_grant = 1'b0;
    n_checks++;
    if (inst_busy !== 1'b0 || mem_req !== 1'b0 || inst !== prev) begin
      n_fail++;
      $display("FAIL abort: busy=%b req=%b inst=%h, want 0 0 %h", inst_busy, mem_req, inst, prev);
    end
    tick();
    n_checks++; if (inst !== prev) begin n_fail++; $display("FAIL abort_hold: %h want %h", inst, prev); end
    run_fetch(32'h344, 1'b0, 100, 100, 1'b0, n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL abort_refetch: %0d cycles want 5", n); end
  endtask

  task automatic test_cache();
    int n1, n2, exp2;
`ifdef ICACHE_EN
    exp2 = 0;
`else
    exp2 = 5;
`endif
    run_fetch(32'h100, 1'b0, 100, 100, 1'b0, n1);
    run_fetch(32'h100, 1'b0, 100, 100, 1'b0, n2);
    n_checks++; if (n1 !== 5) begin n_fail++; $display("FAIL cache_first: %0d cycles want 5", n1); end
    n_checks++; if (n2 !== exp2) begin n_fail++; $display("FAIL cache_second: %0d cycles want %0d", n2, exp2); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int n, idle;
    for (int k = 0; k < 24; k++) begin
      a = 32'h400 + 32'($urandom_range(0, 7)) * 32'd36 + 32'($urandom_range(0, 3));
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        rdy = 1'($urandom_range(0, 1));
        mem_grant = 1'($urandom_range(0, 1));
        tick();
      end
      run_fetch(a, 1'b0, 60, 75, 1'b1, n);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; inst_re = 1'b0; flush = 1'b0; mem_grant = 1'b0; inst_raddr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h100] = 8'h13; mem[12'h101] = 8'h00; mem[12'h102] = 8'h50; mem[12'h103] = 8'h00;
    test_reset();
    test_basic();
    test_grant_stall();
    test_rdy_stall();
    test_reset_mid();
    test_flush_redirect();
    test_flush_abort();
    test_cache();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
